// File: rtl/systolic_feeder.sv
// Skewed feeder for a 4x4 systolic array: holds matrices A and B in register banks
// and streams them diagonally onto a_out/b_out, followed by a zero drain.
module systolic_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_a_en,
    input  logic                    load_b_en,
    input  logic [1:0]              load_idx,
    input  logic [4*DATA_WIDTH-1:0] load_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4*DATA_WIDTH-1:0] a_out,
    output logic [4*DATA_WIDTH-1:0] b_out,
    output logic                    we_out
);

    // state | meaning
    // IDLE  | banks writable, waiting for start
    // FEED  | skewed slices 0..6 being driven (t holds the next slice index)
    // DRAIN | zero fill, drain_cnt counts down to terminal 0
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    localparam int DW = DATA_WIDTH;

    state_t            state, state_nxt;
    logic [2:0]        t, t_nxt;
    logic [3:0]        drain_cnt, drain_cnt_nxt;
    logic              run_nxt, done_nxt, use_slice;
    logic [2:0]        slice_idx;
    logic [4*DW-1:0]   a_slice, b_slice;
    logic              load_ok;

    logic [DW-1:0] a_bank [4][4];   // a_bank[row][k]
    logic [DW-1:0] b_bank [4][4];   // b_bank[k][col]

    assign load_ok   = (state == IDLE) && !start;
    assign slice_idx = (state == IDLE) ? 3'd0 : t;

    always_comb begin : slice_mux
        int k;
        k       = 0;
        a_slice = '0;
        b_slice = '0;
        for (int r = 0; r < 4; r++) begin
            k = int'(slice_idx) - r;
            if (k >= 0 && k <= 3) begin
                a_slice[r*DW +: DW] = a_bank[r][k[1:0]];
                b_slice[r*DW +: DW] = b_bank[k[1:0]][r];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        t_nxt         = t;
        drain_cnt_nxt = drain_cnt;
        run_nxt       = 1'b0;
        done_nxt      = 1'b0;
        use_slice     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FEED;
                    t_nxt     = 3'd1;
                    run_nxt   = 1'b1;
                    use_slice = 1'b1;
                end
            end
            FEED: begin
                run_nxt = 1'b1;
                if (t == 3'd7) begin
                    state_nxt     = DRAIN;
                    t_nxt         = 3'd0;
                    drain_cnt_nxt = 4'(DRAIN_CYCLES - 1);
                end else begin
                    use_slice = 1'b1;
                    t_nxt     = t + 3'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    run_nxt       = 1'b1;
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            t         <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            t         <= t_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out  <= '0;
            b_out  <= '0;
            we_out <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            a_out  <= use_slice ? a_slice : '0;
            b_out  <= use_slice ? b_slice : '0;
            we_out <= run_nxt;
            busy   <= run_nxt;
            done   <= done_nxt;
        end
    end

    // Loads are only honoured in IDLE, and a coincident start takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a_bank[i][j] <= '0;
                    b_bank[i][j] <= '0;
                end
            end
        end else if (load_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (load_a_en) a_bank[load_idx][k] <= load_data[k*DW +: DW];
                if (load_b_en) b_bank[k][load_idx] <= load_data[k*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: matrix model in plain arrays, expected
// skewed slices derived from the matrix indices, randomized loads and runs.
module tb_systolic_feeder;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_a_en = 1'b0, load_b_en = 1'b0;
    logic [1:0]    load_idx = '0;
    logic [4*DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          busy, done, we_out;
    logic [4*DW-1:0] a_out, b_out;

    int checks = 0;
    int failures = 0;

    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];

    systolic_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .load_a_en(load_a_en), .load_b_en(load_b_en),
        .load_idx(load_idx), .load_data(load_data), .start(start),
        .busy(busy), .done(done), .a_out(a_out), .b_out(b_out), .we_out(we_out)
    );

    always #5 clk = ~clk;

    // Element (row r, time t) of the skewed stream: A[r][t-r] / B[t-c][c].
    function automatic logic [31:0] exp_a(input int t);
        logic [31:0] e = '0;
        for (int r = 0; r < 4; r++)
            if (t - r >= 0 && t - r <= 3) e[8*r +: 8] = ma[r][t-r];
        return e;
    endfunction

    function automatic logic [31:0] exp_b(input int t);
        logic [31:0] e = '0;
        for (int c = 0; c < 4; c++)
            if (t - c >= 0 && t - c <= 3) e[8*c +: 8] = mb[t-c][c];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
    endtask

    task automatic load(input bit ea, input bit eb, input logic [1:0] idx, input logic [31:0] data);
        load_a_en = ea; load_b_en = eb; load_idx = idx; load_data = data;
        tick();
        load_a_en = 1'b0; load_b_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ea) ma[idx][k] = data[8*k +: 8];
            if (eb) mb[k][idx] = data[8*k +: 8];
        end
    endtask

    // One full run. issue_start=0 means start was already raised by the previous run.
    task automatic do_run(input bit issue_start, input bit interfere, input bit b2b_next);
        if (issue_start) start = 1'b1;
        for (int i = 0; i <= 7 + D; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (interfere && i == 2) begin
                load_a_en = 1'b1; load_b_en = 1'b1; load_idx = 2'(i);
                load_data = 32'hFFFF_FFFF; start = 1'b1;
            end
            if (interfere && i == 3) begin
                load_a_en = 1'b0; load_b_en = 1'b0; start = 1'b0;
            end
            checks++;
            if (a_out !== (i <= 6 ? exp_a(i) : 32'h0)) begin
                failures++;
                $display("FAIL a_out cyc=%0d got=%h exp=%h", i, a_out, (i <= 6 ? exp_a(i) : 32'h0));
            end
            checks++;
            if (b_out !== (i <= 6 ? exp_b(i) : 32'h0)) begin
                failures++;
                $display("FAIL b_out cyc=%0d got=%h exp=%h", i, b_out, (i <= 6 ? exp_b(i) : 32'h0));
            end
            checks++;
            if ({we_out, busy, done} !== (i < 7 + D ? 3'b110 : 3'b001)) begin
                failures++;
                $display("FAIL ctrl cyc=%0d got we,busy,done=%b exp=%b", i, {we_out, busy, done},
                         (i < 7 + D ? 3'b110 : 3'b001));
            end
            if (b2b_next && i == 7 + D) start = 1'b1;
        end
        if (!b2b_next) begin
            tick();
            checks++;
            if ({we_out, busy, done} !== 3'b000) begin
                failures++;
                $display("FAIL post_run got we,busy,done=%b exp=000", {we_out, busy, done});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        #12;
        checks++;
        if ({a_out, b_out, we_out, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got a=%h b=%h ctrl=%b exp all 0", a_out, b_out, {we_out, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_run(1, 0, 0);   // cleared banks: all-zero slices, full-length run
    endtask

    task automatic test_fixed_pattern();
        for (int r = 0; r < 4; r++)
            load(1, 1, 2'(r), {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)});
        // column-load above wrote B[k][r] = 4r+k+1; overwrite B with the 16+4k+c+1 pattern
        for (int c = 0; c < 4; c++)
            load(0, 1, 2'(c), {8'(16+12+c+1), 8'(16+8+c+1), 8'(16+4+c+1), 8'(16+c+1)});
        start = 1'b1;
        tick(); start = 1'b0;
        checks++;
        if (a_out !== 32'h0000_0001 || b_out !== 32'h0000_0011) begin
            failures++;
            $display("FAIL slice0_const got a=%h b=%h exp a=00000001 b=00000011", a_out, b_out);
        end
        tick(); tick(); tick();
        checks++;
        if (a_out !== {8'd13, 8'd10, 8'd7, 8'd4} || b_out !== {8'd20, 8'd23, 8'd26, 8'd29}) begin
            failures++;
            $display("FAIL slice3_const got a=%h b=%h", a_out, b_out);
        end
        tick(); tick(); tick();
        checks++;
        if (a_out !== {8'd16, 24'h0} || b_out !== {8'd32, 24'h0}) begin
            failures++;
            $display("FAIL slice6_const got a=%h b=%h", a_out, b_out);
        end
        for (int i = 0; i < D + 2; i++) tick();
        do_run(1, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_run(1, 0, 1);
        do_run(0, 0, 0);
    endtask

    task automatic test_busy_ignore();
        do_run(1, 1, 0);
        do_run(1, 0, 0);
    endtask

    task automatic test_start_load_collision();
        start = 1'b1; load_a_en = 1'b1; load_idx = 2'd0; load_data = 32'h0909_0909;
        tick();
        start = 1'b0; load_a_en = 1'b0;
        checks++;
        if (a_out[7:0] !== ma[0][0] || busy !== 1'b1) begin
            failures++;
            $display("FAIL collision got row0=%h busy=%b exp row0=%h busy=1", a_out[7:0], busy, ma[0][0]);
        end
        for (int i = 0; i < 7 + D + 1; i++) tick();
        do_run(1, 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int n = 0; n < 6; n++)
                load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), $urandom);
            do_run(1, 0, 0);
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (a_out !== exp_a(4)) begin
            failures++;
            $display("FAIL midrun_slice4 got=%h exp=%h", a_out, exp_a(4));
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a_out, b_out, we_out, busy, done} !== '0) begin
            failures++;
            $display("FAIL async_reset got a=%h b=%h ctrl=%b exp all 0", a_out, b_out, {we_out, busy, done});
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        do_run(1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fixed_pattern();
        test_back_to_back();
        test_busy_ignore();
        test_start_load_collision();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
